procyon_rs_sched: RTL

Scheduler/controller for one reservation station's array of OPTN_RS_DEPTH procyon_rs_entry instances.
- Dispatch side: allocates a free entry on a reserve request, then steers the next-cycle dispatch to it.
- Issue side: picks the oldest ready entry and broadcasts the age-update controls every entry needs.
- Captures the issued entry's payload into a stallable issue register feeding the functional unit.
- Sits between the dispatcher, the RS entry array and the FU front end.

---
 rtl/procyon_rs_sched_pkg.sv | 25 ++
 rtl/procyon_rs_sched_if.sv | 36 +++
 rtl/procyon_rs_age_select.sv | 61 ++++++
 rtl/procyon_rs_sched.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/procyon_rs_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : procyon_rs_sched_pkg
//  Description : Shared types and widths for the reservation-station scheduler
//                slice: op / op-class encodings and the index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================

// Index width for a count of N items; never narrower than one bit so that a
// single-entry configuration still has a legal index.
`ifndef PCYN_C2I
`define PCYN_C2I(N) (((N) > 1) ? $clog2(N) : 1)
`endif

package procyon_rs_sched_pkg;

    localparam int PCYN_OP_WIDTH    = 5;
    localparam int PCYN_OP_IS_WIDTH = 3;

    typedef logic [PCYN_OP_WIDTH-1:0]    pcyn_op_t;
    typedef logic [PCYN_OP_IS_WIDTH-1:0] pcyn_op_is_t;

endpackage : procyon_rs_sched_pkg

`default_nettype wire

// File: rtl/procyon_rs_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : procyon_rs_sched_if
//  Description : Issue-register bus between the RS scheduler and the FU.
//                master : scheduler (drives valid + payload, samples stall)
//                slave  : functional unit (samples valid + payload, drives stall)
//  Revision    : 1.0 - initial release
// ============================================================================
interface procyon_rs_sched_if
    import procyon_rs_sched_pkg::*;
#(
    parameter int OPTN_DATA_WIDTH    = 32,
    parameter int OPTN_ROB_IDX_WIDTH = 5
) ();

    logic                          valid;
    logic                          stall;
    pcyn_op_t                      op;
    pcyn_op_is_t                   op_is;
    logic [OPTN_DATA_WIDTH-1:0]    imm;
    logic [OPTN_DATA_WIDTH-1:0]    src_data [0:1];
    logic [OPTN_ROB_IDX_WIDTH-1:0] tag;

    modport master (
        output valid, op, op_is, imm, src_data, tag,
        input  stall
    );

    modport slave (
        input  valid, op, op_is, imm, src_data, tag,
        output stall
    );

endinterface : procyon_rs_sched_if

`default_nettype wire

// File: rtl/procyon_rs_age_select.sv
`default_nettype none
// ============================================================================
//  Module      : procyon_rs_age_select
//  Description : Oldest-ready picker. Tournament tree over the ready entries,
//                larger age wins. Occupied ages are unique, so no tie-break.
//  Ports       : i_ready / i_age        - per-entry ready flag and age
//                o_any_ready            - at least one entry is ready
//                o_sel_onehot/idx/age   - winner as one-hot, index and age
//  Revision    : 1.0 - initial release
// ============================================================================
module procyon_rs_age_select #(
    parameter int OPTN_RS_DEPTH = 16,
    parameter int RS_IDX_WIDTH  = `PCYN_C2I(OPTN_RS_DEPTH)
) (
    input  wire [OPTN_RS_DEPTH-1:0]                   i_ready,
    input  wire [OPTN_RS_DEPTH-1:0][RS_IDX_WIDTH-1:0] i_age,
    output logic                                      o_any_ready,
    output logic [OPTN_RS_DEPTH-1:0]                  o_sel_onehot,
    output logic [RS_IDX_WIDTH-1:0]                   o_sel_idx,
    output logic [RS_IDX_WIDTH-1:0]                   o_sel_age
);

    // Heap layout: node n has children 2n+1 / 2n+2; leaves occupy
    // DEPTH-1 .. 2*DEPTH-2, giving ceil(log2(DEPTH)) comparison levels.
    localparam int C_NODES = 2 * OPTN_RS_DEPTH - 1;

    logic [C_NODES-1:0]                   w_vld;
    logic [C_NODES-1:0][RS_IDX_WIDTH-1:0] w_age;
    logic [C_NODES-1:0][RS_IDX_WIDTH-1:0] w_idx;

    always_comb begin
        w_vld = '0;
        w_age = '0;
        w_idx = '0;
        for (int k = 0; k < OPTN_RS_DEPTH; k++) begin
            w_vld[OPTN_RS_DEPTH-1+k] = i_ready[k];
            w_age[OPTN_RS_DEPTH-1+k] = i_age[k];
            w_idx[OPTN_RS_DEPTH-1+k] = RS_IDX_WIDTH'(k);
        end
        // Evaluate bottom-up so every child is resolved before its parent.
        for (int n = OPTN_RS_DEPTH - 2; n >= 0; n--) begin
            if (w_vld[2*n+2] && (!w_vld[2*n+1] || (w_age[2*n+2] > w_age[2*n+1]))) begin
                w_vld[n] = 1'b1;
                w_age[n] = w_age[2*n+2];
                w_idx[n] = w_idx[2*n+2];
            end else begin
                w_vld[n] = w_vld[2*n+1];
                w_age[n] = w_age[2*n+1];
                w_idx[n] = w_idx[2*n+1];
            end
        end
    end

    assign o_any_ready  = w_vld[0];
    assign o_sel_idx    = w_idx[0];
    assign o_sel_age    = w_age[0];
    assign o_sel_onehot = w_vld[0] ? (OPTN_RS_DEPTH'(1) << w_idx[0]) : '0;

endmodule : procyon_rs_age_select

`default_nettype wire

// File: rtl/procyon_rs_sched.sv
`default_nettype none
// ============================================================================
//  Module      : procyon_rs_sched
//  Description : Scheduler for one reservation station's entry array.
//                Reserve : lowest-index empty entry, strobed the same cycle.
//                Dispatch: next-cycle op steered to the reserved entry.
//                Issue   : oldest ready entry, payload captured into a
//                          stallable issue register on fu_bus.
//  Ports       : i_rs_reserve_en/i_rs_dispatch_en/o_rs_stall - dispatcher
//                i_entry_*  - entry array status and payload
//                o_entry_*  - one-hot per-entry strobes
//                o_dispatching/o_issuing/o_issue_entry_age - age broadcast
//                fu_bus     - issue register toward the functional unit
//  Revision    : 1.0 - initial release
// ============================================================================
module procyon_rs_sched
    import procyon_rs_sched_pkg::*;
#(
    parameter  int OPTN_DATA_WIDTH    = 32,
    parameter  int OPTN_ROB_IDX_WIDTH = 5,
    parameter  int OPTN_RS_DEPTH      = 16,
    localparam int RS_IDX_WIDTH       = `PCYN_C2I(OPTN_RS_DEPTH)
) (
    input  wire                                                  clk,
    input  wire                                                  rst,
    input  wire                                                  i_flush,
    input  wire                                                  i_rs_reserve_en,
    input  wire                                                  i_rs_dispatch_en,
    output logic                                                 o_rs_stall,
    input  wire [OPTN_RS_DEPTH-1:0]                              i_entry_empty,
    input  wire [OPTN_RS_DEPTH-1:0]                              i_entry_ready,
    input  wire [OPTN_RS_DEPTH-1:0][RS_IDX_WIDTH-1:0]            i_entry_age,
    input  wire pcyn_op_t    [OPTN_RS_DEPTH-1:0]                 i_entry_op,
    input  wire pcyn_op_is_t [OPTN_RS_DEPTH-1:0]                 i_entry_op_is,
    input  wire [OPTN_RS_DEPTH-1:0][OPTN_DATA_WIDTH-1:0]         i_entry_imm,
    input  wire [OPTN_RS_DEPTH-1:0][OPTN_ROB_IDX_WIDTH-1:0]      i_entry_tag,
    input  wire [OPTN_RS_DEPTH-1:0][1:0][OPTN_DATA_WIDTH-1:0]    i_entry_src_data,
    output logic [OPTN_RS_DEPTH-1:0]                             o_entry_reserve_en,
    output logic [OPTN_RS_DEPTH-1:0]                             o_entry_dispatch_en,
    output logic [OPTN_RS_DEPTH-1:0]                             o_entry_issue_en,
    output logic                                                 o_dispatching,
    output logic                                                 o_issuing,
    output logic [RS_IDX_WIDTH-1:0]                              o_issue_entry_age,
    procyon_rs_sched_if.master                                   fu_bus
);

    // ---------------- reserve / dispatch ----------------
    logic                          r_rsv_vld;
    logic [RS_IDX_WIDTH-1:0]       r_rsv_idx;
    logic [RS_IDX_WIDTH-1:0]       w_free_idx;
    logic                          w_rsv_fire;
    logic                          w_disp_fire;

    // Lowest-index empty entry: scan downwards so the last hit wins.
    always_comb begin
        w_free_idx = '0;
        for (int k = OPTN_RS_DEPTH - 1; k >= 0; k--) begin
            if (i_entry_empty[k]) begin
                w_free_idx = RS_IDX_WIDTH'(k);
            end
        end
    end

    assign o_rs_stall          = ~|i_entry_empty;
    assign w_rsv_fire          = i_rs_reserve_en & ~o_rs_stall & ~i_flush;
    assign w_disp_fire         = i_rs_dispatch_en & r_rsv_vld & ~i_flush;
    assign o_entry_reserve_en  = w_rsv_fire  ? (OPTN_RS_DEPTH'(1) << w_free_idx) : '0;
    assign o_entry_dispatch_en = w_disp_fire ? (OPTN_RS_DEPTH'(1) << r_rsv_idx)  : '0;
    assign o_dispatching       = w_disp_fire;

    // A fresh reserve takes priority over clearing: the dispatch this cycle
    // consumes the old reservation while the new one is recorded.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rsv_vld <= 1'b0;
            r_rsv_idx <= '0;
        end else if (w_rsv_fire) begin
            r_rsv_vld <= 1'b1;
            r_rsv_idx <= w_free_idx;
        end else if (w_disp_fire) begin
            r_rsv_vld <= 1'b0;
        end
    end

    // ---------------- issue ----------------
    logic                                 w_any_ready;
    logic [OPTN_RS_DEPTH-1:0]             w_sel_onehot;
    logic [RS_IDX_WIDTH-1:0]              w_sel_idx;
    logic [RS_IDX_WIDTH-1:0]              w_sel_age;
    logic                                 w_issue_fire;

    procyon_rs_age_select #(
        .OPTN_RS_DEPTH (OPTN_RS_DEPTH),
        .RS_IDX_WIDTH  (RS_IDX_WIDTH)
    ) u_age_select (
        .i_ready      (i_entry_ready),
        .i_age        (i_entry_age),
        .o_any_ready  (w_any_ready),
        .o_sel_onehot (w_sel_onehot),
        .o_sel_idx    (w_sel_idx),
        .o_sel_age    (w_sel_age)
    );

    logic                               r_issue_valid;
    pcyn_op_t                           r_issue_op;
    pcyn_op_is_t                        r_issue_op_is;
    logic [OPTN_DATA_WIDTH-1:0]         r_issue_imm;
    logic [1:0][OPTN_DATA_WIDTH-1:0]    r_issue_src;
    logic [OPTN_ROB_IDX_WIDTH-1:0]      r_issue_tag;

    // The issue register can take a new op when empty or draining this cycle.
    assign w_issue_fire      = w_any_ready & ~i_flush & (~r_issue_valid | ~fu_bus.stall);
    assign o_entry_issue_en  = w_issue_fire ? w_sel_onehot : '0;
    assign o_issuing         = w_issue_fire;
    assign o_issue_entry_age = w_issue_fire ? w_sel_age : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_valid <= 1'b0;
            r_issue_op    <= '0;
            r_issue_op_is <= '0;
            r_issue_imm   <= '0;
            r_issue_src   <= '0;
            r_issue_tag   <= '0;
        end else if (i_flush) begin
            r_issue_valid <= 1'b0;
        end else if (w_issue_fire) begin
            r_issue_valid <= 1'b1;
            r_issue_op    <= i_entry_op[w_sel_idx];
            r_issue_op_is <= i_entry_op_is[w_sel_idx];
            r_issue_imm   <= i_entry_imm[w_sel_idx];
            r_issue_src   <= i_entry_src_data[w_sel_idx];
            r_issue_tag   <= i_entry_tag[w_sel_idx];
        end else if (!fu_bus.stall) begin
            r_issue_valid <= 1'b0;
        end
    end

    assign fu_bus.valid       = r_issue_valid;
    assign fu_bus.op          = r_issue_op;
    assign fu_bus.op_is       = r_issue_op_is;
    assign fu_bus.imm         = r_issue_imm;
    assign fu_bus.src_data[0] = r_issue_src[0];
    assign fu_bus.src_data[1] = r_issue_src[1];
    assign fu_bus.tag         = r_issue_tag;

    // A dispatch without an outstanding reservation indicates a dispatcher bug.
    a_dispatch_needs_rsv: assert property (@(posedge clk) disable iff (rst)
        !(i_rs_dispatch_en && !i_flush && !r_rsv_vld));

endmodule : procyon_rs_sched

`default_nettype wire
